// File: rtl/cache_arb_pkg.sv
// Shared types and default sizes for the cache arbiter.
// Optional build macro: CACHE_ARB_RR_EN (round-robin tie-break).
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_e;

endpackage

// File: rtl/cache_arb_if.sv
// Bundle of the icache, dcache and memory line ports around the arbiter.
// Optional build macro affecting the arbiter: CACHE_ARB_RR_EN.
//
// Handshake: a requester raises read (or write) as a level and holds address,
// command and wdata stable until the cycle its resp is 1; resp is a one-cycle
// completion strobe that also qualifies rdata. The memory side follows the
// same rule: mem_read/mem_write stay high until the cycle mem_resp is 1.
interface cache_arb_if #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W
);

  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_read;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic [ADDR_W-1:0] d_pmem_address;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  // Arbiter side.
  modport slave (
    input  i_pmem_address, i_pmem_read,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output mem_address, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp
  );

  // Caches plus memory side.
  modport master (
    output i_pmem_address, i_pmem_read,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_address, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_arbiter.sv
// Shares one line-granular memory port between the icache and the dcache.
// One line transaction is granted at a time; the response is routed only to
// the granted cache. Build macro CACHE_ARB_RR_EN selects round-robin on ties;
// without it the dcache always wins a tie.
module cache_arbiter #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_arb_if.slave              bus,
  output cache_arb_pkg::arb_state_e state_debug
);

  import cache_arb_pkg::*;

  arb_state_e state;
  arb_state_e state_next;
  arb_req_e   tie_winner;

  logic i_req;
  logic d_req;

  logic [ADDR_W-1:0] mem_address_c;
  logic [LINE_W-1:0] mem_wdata_c;
  logic              mem_read_c;
  logic              mem_write_c;
  logic              i_resp_c;
  logic              d_resp_c;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef CACHE_ARB_RR_EN
  // Pointer names the requester that wins the next tie.
  arb_req_e rr_ptr;
  arb_req_e rr_ptr_next;

  assign tie_winner = rr_ptr;

  // Pointer register, reset to the icache.
  always_ff @(posedge clk) begin
    if (!rst) rr_ptr <= REQ_I;
    else      rr_ptr <= rr_ptr_next;
  end

  // On every grant the pointer moves to the requester that was not granted.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (state == IDLE) begin
      if (state_next == SERVE_I)      rr_ptr_next = REQ_D;
      else if (state_next == SERVE_D) rr_ptr_next = REQ_I;
    end
  end
`else
  assign tie_winner = REQ_D;
`endif

  // State register; reset returns to IDLE and discards any transaction.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: grant from IDLE, release on mem_resp in a SERVE state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_req && d_req)
          state_next = (tie_winner == REQ_I) ? SERVE_I : SERVE_D;
        else if (d_req)
          state_next = SERVE_D;
        else if (i_req)
          state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output steering: forward the granted requester, gate resp to it only.
  always_comb begin
    mem_address_c = '0;
    mem_wdata_c   = '0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    i_resp_c      = 1'b0;
    d_resp_c      = 1'b0;
    case (state)
      SERVE_I: begin
        mem_read_c    = 1'b1;
        mem_address_c = bus.i_pmem_address;
        i_resp_c      = bus.mem_resp;
      end
      SERVE_D: begin
        mem_read_c    = bus.d_pmem_read;
        mem_write_c   = bus.d_pmem_write;
        mem_address_c = bus.d_pmem_address;
        mem_wdata_c   = bus.d_pmem_wdata;
        d_resp_c      = bus.mem_resp;
      end
      default: ;
    endcase
  end

  assign bus.mem_address  = mem_address_c;
  assign bus.mem_wdata    = mem_wdata_c;
  assign bus.mem_read     = mem_read_c;
  assign bus.mem_write    = mem_write_c;
  assign bus.i_pmem_resp  = i_resp_c;
  assign bus.d_pmem_resp  = d_resp_c;

  // Read data fans out to both caches; only resp qualifies it.
  assign bus.i_pmem_rdata = bus.mem_rdata;
  assign bus.d_pmem_rdata = bus.mem_rdata;

  assign state_debug = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter. Honours CACHE_ARB_RR_EN when defined.
module tb_cache_arbiter;

  import cache_arb_pkg::*;

  typedef logic [LINE_W-1:0] word_t;

  logic       clk;
  logic       rst;
  arb_state_e state_dbg;

  int checks   = 0;
  int failures = 0;

  // {is_dcache, line data} expected for each response strobe.
  logic [LINE_W:0] exp_q[$];

  cache_arb_if bus ();

  cache_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_debug (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Illegal dcache command combination must never be driven.
  always @(negedge clk) begin
    if (rst) assert (!(bus.d_pmem_read && bus.d_pmem_write))
      else $error("dcache read and write both high");
  end

  // Scoreboard: every response strobe pops one expected entry.
  always @(negedge clk) begin
    logic [LINE_W:0] e;
    if (bus.i_pmem_resp || bus.d_pmem_resp) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", word_t'({bus.d_pmem_resp, bus.i_pmem_resp}), word_t'(0));
      end else begin
        e = exp_q.pop_front();
        check("resp_who", word_t'({bus.d_pmem_resp, bus.i_pmem_resp}),
              word_t'(e[LINE_W] ? 2'b10 : 2'b01));
        check("resp_data", bus.d_pmem_resp ? bus.d_pmem_rdata : bus.i_pmem_rdata,
              e[LINE_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.i_pmem_address = '0;
    bus.i_pmem_read    = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_wdata   = '0;
    bus.mem_rdata      = '0;
    bus.mem_resp       = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", word_t'(bus.mem_read), word_t'(0));
    check("rst_mem_write", word_t'(bus.mem_write), word_t'(0));
    check("rst_mem_address", word_t'(bus.mem_address), word_t'(0));
    check("rst_mem_wdata", bus.mem_wdata, word_t'(0));
    check("rst_resps", word_t'({bus.i_pmem_resp, bus.d_pmem_resp}), word_t'(0));
    check("rst_state", word_t'(state_dbg), word_t'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Cycles from the request's own cycle until mem_read/mem_write is seen.
  task automatic wait_grant(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!(bus.mem_read || bus.mem_write) && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Memory answers after lat cycles; returns at the negedge of the resp cycle.
  task automatic respond(input int lat, input word_t data);
    repeat (lat) @(posedge clk);
    #1;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = data;
    @(negedge clk);
  endtask

  task automatic end_resp();
    @(posedge clk);
    #1;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = word_t'({$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int    lat;
    logic  exp_d;
    word_t data_i  = {32{8'hA5}};
    word_t data_wb = {8{32'h12345678}};
    word_t data_rd;
    word_t data_tie;

    reset_dut();

    // Spurious mem_resp in IDLE.
    bus.mem_resp = 1'b1;
    @(negedge clk);
    check("idle_spurious_resp", word_t'({bus.i_pmem_resp, bus.d_pmem_resp}), word_t'(0));
    check("idle_spurious_state", word_t'(state_dbg), word_t'(IDLE));
    @(posedge clk);
    #1;
    bus.mem_resp = 1'b0;

    // icache-only read.
    bus.i_pmem_address = 32'h0000_1000;
    bus.i_pmem_read    = 1'b1;
    wait_grant(lat);
    check("i_grant_lat", word_t'(lat), word_t'(1));
    check("i_mem_read", word_t'({bus.mem_read, bus.mem_write}), word_t'(2'b10));
    check("i_mem_address", word_t'(bus.mem_address), word_t'(32'h0000_1000));
    exp_q.push_back({1'b0, data_i});
    respond(5, data_i);
    check("i_no_d_resp", word_t'(bus.d_pmem_resp), word_t'(0));
    end_resp();
    bus.i_pmem_read = 1'b0;
    @(negedge clk);
    check("i_back_idle", word_t'(state_dbg), word_t'(IDLE));
    @(posedge clk);
    #1;

    // dcache write-back followed by a fill.
    bus.d_pmem_address = 32'h0000_2000;
    bus.d_pmem_wdata   = data_wb;
    bus.d_pmem_write   = 1'b1;
    wait_grant(lat);
    check("wb_grant_lat", word_t'(lat), word_t'(1));
    check("wb_cmd", word_t'({bus.mem_read, bus.mem_write}), word_t'(2'b01));
    check("wb_address", word_t'(bus.mem_address), word_t'(32'h0000_2000));
    check("wb_wdata", bus.mem_wdata, data_wb);
    exp_q.push_back({1'b1, data_i});
    respond(3, data_i);
    check("wb_no_i_resp", word_t'(bus.i_pmem_resp), word_t'(0));
    end_resp();
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_wdata   = '0;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_3000;
    data_rd = word_t'({$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom});
    wait_grant(lat);
    check("fill_grant_lat", word_t'(lat), word_t'(1));
    check("fill_cmd", word_t'({bus.mem_read, bus.mem_write}), word_t'(2'b10));
    check("fill_address", word_t'(bus.mem_address), word_t'(32'h0000_3000));
    exp_q.push_back({1'b1, data_rd});
    respond($urandom_range(1, 6), data_rd);
    end_resp();
    bus.d_pmem_read = 1'b0;

    // Simultaneous requests held for four grants, from a fresh pointer.
    reset_dut();
    bus.i_pmem_address = 32'h0000_0100;
    bus.i_pmem_read    = 1'b1;
    bus.d_pmem_address = 32'h0000_0200;
    bus.d_pmem_read    = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
      exp_d = (k % 2 == 1);
`else
      exp_d = 1'b1;
`endif
      data_tie = word_t'({$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom});
      wait_grant(lat);
      check("tie_grant_lat", word_t'(lat), word_t'(1));
      check("tie_state", word_t'(state_dbg), word_t'(exp_d ? SERVE_D : SERVE_I));
      check("tie_address", word_t'(bus.mem_address),
            word_t'(exp_d ? 32'h0000_0200 : 32'h0000_0100));
      exp_q.push_back({exp_d, data_tie});
      respond($urandom_range(1, 4), data_tie);
      end_resp();
    end
    bus.i_pmem_read = 1'b0;
    bus.d_pmem_read = 1'b0;
    @(negedge clk);
    check("tie_back_idle", word_t'(state_dbg), word_t'(IDLE));

    // Reset in the middle of a dcache read.
    @(posedge clk);
    #1;
    bus.d_pmem_address = 32'h0000_4000;
    bus.d_pmem_read    = 1'b1;
    wait_grant(lat);
    check("mid_grant_state", word_t'(state_dbg), word_t'(SERVE_D));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus.d_pmem_read = 1'b0;
    bus.mem_resp    = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", word_t'({bus.mem_read, bus.mem_write}), word_t'(0));
    check("mid_rst_state", word_t'(state_dbg), word_t'(IDLE));
    check("mid_rst_late_resp", word_t'({bus.i_pmem_resp, bus.d_pmem_resp}), word_t'(0));
    end_resp();
    repeat (2) @(negedge clk);

    check("queue_empty", word_t'(exp_q.size()), word_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
